// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: in-order FPU program sequencer (FETCH/ISSUE/WAIT/WB); define FPU_SEQ_TIMEOUT_EN to add a WAIT watchdog
module fpu_seq_ctrl #(
    parameter int PROG_LEN    = 15,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  instr_addr,
    input  logic [23:0] instr_data,
    output logic [4:0]  rf_raddr_a,
    output logic [4:0]  rf_raddr_b,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    output logic        alu_req,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] WB    = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [3:0] LAST_PC = 4'(PROG_LEN - 1);

    logic [2:0]  state;
    logic [3:0]  pc;
    logic [23:0] ir;
    logic [31:0] result;
    logic        halt;
    logic        timeout;
    logic        unused_bits;

    assign halt        = ir[13:9] == 5'b11111;
    assign instr_addr  = pc;
    assign rf_raddr_a  = ir[23:19];
    assign rf_raddr_b  = ir[18:14];
    assign alu_req     = state == WAIT;
    assign rf_we       = state == WB;
    assign rf_waddr    = ir[8:4];
    assign rf_wdata    = result;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign unused_bits = ^{ir[3:0], TIMEOUT_CYC != 0};

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt;
    logic       err_q;
    assign timeout = cnt == LAST_CNT;
    assign err     = err_q;
    // WAIT watchdog: count restarts on every WAIT entry; err is sticky until the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 8'd1;
            if (state == IDLE && start) err_q <= 1'b0;
            else if (state == WAIT && !alu_done && timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // sequencer: one instruction at a time, write-back finishes before the next fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            ir     <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pc    <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    ir    <= instr_data;
                    state <= ISSUE;
                end
                ISSUE: if (halt) state <= DONE;
                else begin
                    alu_a  <= rf_rdata_a;
                    alu_b  <= rf_rdata_b;
                    alu_op <= ir[13:9];
                    state  <= WAIT;
                end
                WAIT: if (alu_done) begin
                    result <= alu_result;
                    state  <= WB;
                end else if (timeout) state <= DONE;
                WB: if (pc == LAST_PC) state <= DONE;
                else begin
                    pc    <= pc + 4'd1;
                    state <= FETCH;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: scoreboard bench for fpu_seq_ctrl (15-word and 1-word program instances)
module tb_fpu_seq_ctrl;
    typedef struct packed {
        logic [3:0]  pc;
        logic [4:0]  dest;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  instr_addr, instr_addr1;
    logic [23:0] instr_data, instr_data1;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_raddr_a1, rf_raddr_b1;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic [31:0] alu_a, alu_b, alu_result, alu_a1, alu_b1;
    logic [4:0]  alu_op, alu_op1, rf_waddr, rf_waddr1;
    logic        alu_req, alu_done, alu_req1, rf_we, rf_we1;
    logic [31:0] rf_wdata, rf_wdata1;
    logic        busy, done, err, busy1, done1, err1;

    logic [23:0] mem [16];
    logic [31:0] rf [32];
    int alu_lat = 1;
    bit alu_hang = 1'b0, alu_stray = 1'b0;
    int wait_cnt = 0, cyc = 0;
    int tests = 0, fails = 0;
    int nwr = 0, req_cycles = 0, unstable = 0, done_cnt = 0;
    int wb1_cyc = 0, done1_cnt = 0;
    bit prev_req = 1'b0;
    logic [68:0] snap;
    exp_t q0[$], q1[$];
    exp_t e0, e1;

    fpu_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .instr_addr(instr_addr), .instr_data(instr_data),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_req(alu_req), .alu_done(alu_done),
        .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .err(err)
    );

    fpu_seq_ctrl #(.PROG_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .instr_addr(instr_addr1), .instr_data(instr_data1),
        .rf_raddr_a(rf_raddr_a1), .rf_raddr_b(rf_raddr_b1), .rf_rdata_a(32'd0), .rf_rdata_b(32'd0),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_req(alu_req1), .alu_done(alu_req1),
        .alu_result(32'h3E5A0000), .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
        .busy(busy1), .done(done1), .err(err1)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        return (a ^ {27'd0, op}) + b + 32'h100;
    endfunction

    assign instr_data  = mem[instr_addr];
    assign instr_data1 = 24'h000E20;
    assign rf_rdata_a  = rf[rf_raddr_a];
    assign rf_rdata_b  = rf[rf_raddr_b];
    assign alu_done    = (alu_req && !alu_hang && wait_cnt == alu_lat - 1) || alu_stray;
    assign alu_result  = alu_fn(alu_a, alu_b, alu_op);

    // external register file, ALU latency counter and cycle counter
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        wait_cnt <= alu_req ? wait_cnt + 1 : 0;
        if (rst) for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h01010101 + 32'h11;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor for the 15-word instance
    always @(negedge clk) begin
        if (rf_we) begin
            nwr++;
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got write waddr=%0d wdata=%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                e0 = q0.pop_front();
                check("wb_pc", 32'(instr_addr), 32'(e0.pc));
                check("wb_addr", 32'(rf_waddr), 32'(e0.dest));
                check("wb_data", rf_wdata, e0.val);
            end
        end
        if (done) done_cnt++;
        if (alu_req) begin
            req_cycles++;
            if (prev_req && {alu_a, alu_b, alu_op} != snap) unstable++;
            snap = {alu_a, alu_b, alu_op};
        end
        prev_req = alu_req;
    end

    // monitor for the 1-word instance
    always @(negedge clk) begin
        if (rf_we1) begin
            wb1_cyc = cyc;
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL p1_wb_unexpected: got write waddr=%0d expected no write", rf_waddr1);
            end else begin
                e1 = q1.pop_front();
                check("p1_wb_addr", 32'(rf_waddr1), 32'(e1.dest));
                check("p1_wb_data", rf_wdata1, e1.val);
            end
        end
        if (done1) done1_cnt++;
    end

    // launch a program; optionally predict its write-backs; lat = inclusive cycles from start sample to done
    task automatic run(input int limit, input bit model, input bit poke, output int lat);
        logic [31:0] ref_rf [32];
        logic [23:0] w;
        logic [31:0] v;
        exp_t e;
        int s, n;
        if (model) begin
            ref_rf = rf;
            for (int p = 0; p < 15; p++) begin
                w = mem[p];
                if (w[13:9] == 5'h1f) break;
                v = alu_fn(ref_rf[w[23:19]], ref_rf[w[18:14]], w[13:9]);
                e.pc = p[3:0];
                e.dest = w[8:4];
                e.val = v;
                q0.push_back(e);
                ref_rf[w[8:4]] = v;
            end
        end
        nwr = 0; req_cycles = 0; unstable = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < limit) begin
            start = poke && n == 20;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        lat = done ? cyc - s + 1 : -1;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: got no done within %0d cycles expected done", limit);
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat, n;
        exp_t e;
        for (int p = 0; p < 16; p++)
            mem[p] = {5'(p % 7), 5'((p + 1) % 7), 5'(p + 1), 5'((p + 2) % 7), 4'h0};
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_alu_req", 32'(alu_req), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_pc", 32'(instr_addr), 0);
        check("rst_alu_ops", {alu_a | alu_b, 27'd0, alu_op} == 0 ? 32'd0 : 32'd1, 0);
        rst = 1'b0;

        alu_stray = 1'b1;
        @(negedge clk);
        alu_stray = 1'b0;
        @(negedge clk);
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_writes", 32'(nwr), 0);

        e.pc = 4'd0; e.dest = 5'd2; e.val = 32'h3E5A0000;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b1;
        lat = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin @(negedge clk); n++; end
        check("p1_done_seen", 32'(done1), 1);
        check("p1_wb_latency", 32'(wb1_cyc - lat + 1), 4);
        @(negedge clk);
        check("p1_busy_fall", 32'(busy1), 0);
        check("p1_done_once", 32'(done1_cnt), 1);
        check("p1_queue_empty", 32'(q1.size()), 0);

        run(200, 1'b1, 1'b1, lat);
        check("full_done_latency", 32'(lat), 61);
        check("full_writes", 32'(nwr), 15);
        check("full_queue_empty", 32'(q0.size()), 0);
        check("full_done_once", 32'(done_cnt), 1);
        check("full_busy_fall", 32'(busy), 0);

        mem[1] = {5'd1, 5'd2, 5'h1f, 5'd3, 4'h0};
        run(200, 1'b1, 1'b0, lat);
        check("halt_writes", 32'(nwr), 1);
        check("halt_req_cycles", 32'(req_cycles), 1);
        check("halt_queue_empty", 32'(q0.size()), 0);

        alu_lat = 10;
        run(200, 1'b1, 1'b0, lat);
        check("slow_req_cycles", 32'(req_cycles), 10);
        check("slow_unstable", 32'(unstable), 0);
        check("slow_writes", 32'(nwr), 1);

        nwr = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(alu_req && wait_cnt == 2) && n < 20) begin @(negedge clk); n++; end
        check("rstw_in_wait3", 32'(alu_req && wait_cnt == 2), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_alu_req", 32'(alu_req), 0);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_rf_we", 32'(rf_we), 0);
        repeat (3) @(negedge clk);
        check("rstw_no_write", 32'(nwr), 0);
        alu_lat = 1;
        mem[1] = {5'd1, 5'd2, 5'd2, 5'd3, 4'h0};
        run(200, 1'b1, 1'b0, lat);
        check("rerun_latency", 32'(lat), 61);
        check("rerun_writes", 32'(nwr), 15);

        alu_hang = 1'b1;
`ifdef FPU_SEQ_TIMEOUT_EN
        run(400, 1'b0, 1'b0, lat);
        check("to_err", 32'(err), 1);
        check("to_req_cycles", 32'(req_cycles), 255);
        check("to_done_latency", 32'(lat), 258);
        check("to_writes", 32'(nwr), 0);
        alu_hang = 1'b0;
        repeat (2) @(negedge clk);
        check("to_err_sticky", 32'(err), 1);
        run(200, 1'b1, 1'b0, lat);
        check("to_err_cleared", 32'(err), 0);
        check("to_after_writes", 32'(nwr), 15);
`else
        nwr = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("hang_busy", 32'(busy), 1);
        check("hang_alu_req", 32'(alu_req), 1);
        check("hang_err", 32'(err), 0);
        check("hang_writes", 32'(nwr), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        alu_hang = 1'b0;
        check("hang_rst_busy", 32'(busy), 0);
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_seq_ctrl.md
FPU_SEQ_CTRL -- requirements
Module: fpu_seq_ctrl

Interface
REQ-001 Parameter PROG_LEN, default 15, number of instruction words executed per program (range 1-16).
REQ-002 Parameter TIMEOUT_CYC, default 255, maximum cycles spent in WAIT before abort (used only with FPU_SEQ_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  program launch request; sampled only in IDLE.
REQ-006 instr_addr  output  4  instruction-memory read address (PC).
REQ-007 instr_data  input  24  instruction word, combinationally valid in the same cycle as instr_addr; fields are src1[23:19], src2[18:14], op[13:9], dest[8:4], and [3:0] unused.
REQ-008 rf_raddr_a / rf_raddr_b  output  5 each  register-file read addresses.
REQ-009 rf_rdata_a / rf_rdata_b  input  32 each  combinational register-file read data.
REQ-010 alu_a / alu_b  output  32 each  ALU operands; alu_op  output  5  ALU opcode.
REQ-011 alu_req  output  1  ALU operation request; alu_done  input  1  result valid; alu_result  input  32.
REQ-012 rf_we  output  1; rf_waddr  output  5; rf_wdata  output  32  register-file write port.
REQ-013 busy  output  1  high in every state except IDLE; done  output  1  one-cycle completion pulse; err  output  1  sticky timeout flag.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, ISSUE, WAIT, WB and DONE.
REQ-015 IDLE: when start=1, the block SHALL clear the PC to 0 and clear err, then go to FETCH; otherwise it SHALL stay in IDLE.
REQ-016 FETCH: the block SHALL drive instr_addr=PC, latch instr_data into the IR, and go to ISSUE.
REQ-017 ISSUE: the block SHALL drive rf_raddr_a=IR[23:19] and rf_raddr_b=IR[18:14]. It SHALL register rf_rdata_a/b into alu_a/b and IR[13:9] into alu_op, then go to WAIT. If IR[13:9]=5'b11111 (HALT), it SHALL instead go to DONE with no ALU request and no write.
REQ-018 WAIT: alu_req SHALL be 1, with alu_a/b/op held stable. On alu_done=1 the block SHALL capture alu_result, and alu_req SHALL be 0 from the next cycle; the state SHALL then be WB.
REQ-019 WB: for exactly one cycle the block SHALL drive rf_we=1, rf_waddr=IR[8:4] and rf_wdata equal to the captured result. If PC==PROG_LEN-1 it SHALL go to DONE; otherwise it SHALL set PC=PC+1 and go to FETCH.
REQ-020 DONE: done SHALL be 1 for one cycle, then the block SHALL go to IDLE.
REQ-021 Per-instruction latency SHALL be 3+N cycles from FETCH entry to the next FETCH entry, where N≥1 is the number of WAIT cycles; with alu_done in the first WAIT cycle this is 4 cycles.
REQ-022 start while busy=1 SHALL be ignored; alu_done outside WAIT SHALL be ignored.
REQ-023 Instructions SHALL execute strictly in order, with write-back completed before the next FETCH, so read-after-write on any register returns the new value.
REQ-024 rf_we SHALL be 0 in every state except WB; dest=0 SHALL be a legal write target.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL enter IDLE. PC, IR, alu_a, alu_b, alu_op and result SHALL be 0. alu_req, rf_we, busy, done and err SHALL be 0.
REQ-026 Reset SHALL take priority over all other inputs, including mid-WAIT. alu_req SHALL drop in the cycle after the reset edge, and no pending write-back SHALL occur.

Configuration
REQ-027 With FPU_SEQ_TIMEOUT_EN defined, an 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle. If it reaches TIMEOUT_CYC without alu_done, the block SHALL drop alu_req, set err=1, skip WB and go to DONE; err SHALL remain 1 until the next accepted start or rst.
REQ-028 Without FPU_SEQ_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL last indefinitely, and err SHALL be tied to 0; the port SHALL exist in both builds.

Verification
REQ-029 Setup: PROG_LEN=1, mem[0] src1=0, src2=0, op=7, dest=2, ALU returning done after 1 cycle with result 0x3E5A0000. Stimulus: pulse start. Required response: rf_we=1 with waddr=2 and wdata=0x3E5A0000 exactly 4 cycles after FETCH entry, then done pulses once and busy falls.
REQ-030 Setup: PROG_LEN=15 with 1-cycle ALU. Required response: 15 write-backs, done asserted exactly 61 cycles after start is sampled, and each instr_addr 0..14 visited once in order.
REQ-031 Setup: mem[1] op=5'b11111, PROG_LEN=15. Required response: exactly 1 write, then done, with no alu_req for instruction 1.
REQ-032 Setup: ALU done delayed 10 cycles. Required response: alu_req high for exactly 10 cycles, with alu_a/b/op constant throughout.
REQ-033 Stimulus: rst asserted during the 3rd WAIT cycle. Required response: next cycle IDLE, alu_req=0, busy=0, and no rf_we; a subsequent start reruns from PC=0.
REQ-034 Setup: FPU_SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=255, alu_done never asserted. Required response: err=1 and a done pulse after 255 WAIT cycles with no rf_we; err clears on the next start.
